// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: operand forwarding, load-use and taken-branch hazards, and a data-memory wait stall.
// Defining HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt cycle counters.
module hazard_ctrl_param #(
    parameter int AW      = 5,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1D,
    input  logic [AW-1:0] rs2D,
    input  logic [AW-1:0] rs1E,
    input  logic [AW-1:0] rs2E,
    input  logic [AW-1:0] rdE,
    input  logic          regwriteE,
    input  logic          memreadE,
    input  logic          isbranchtakenE,
    input  logic [AW-1:0] rdM,
    input  logic          regwriteM,
    input  logic          memreqM,
    input  logic [AW-1:0] rdW,
    input  logic          regwriteW,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          stallM,
    output logic          flushD,
    output logic          flushE
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_stall_s;
    logic          load_use_s;

    // M-stage result has priority over W; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rd_m, input logic we_m,
                                           input logic [AW-1:0] rd_w, input logic we_w);
        logic [1:0] sel;
        if (we_m && (rd_m != {AW{1'b0}}) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (we_w && (rd_w != {AW{1'b0}}) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Memory-wait FSM next state; memreqM is ignored while waiting, including the release cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_stall_s = 1'b0;
        case (state_q)
            RUN: begin
                if (memreqM && (MEM_LAT > 1)) begin
                    mem_stall_s = 1'b1;
                    state_d     = MEMWAIT;
                    cnt_d       = CNT_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            MEMWAIT: begin
                if (cnt_q != {CW{1'b0}}) begin
                    mem_stall_s = 1'b1;
                    cnt_d       = cnt_q - CNT_ONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Output resolution: memory stall beats taken branch, which beats load-use.
    always_comb begin
        forwardaE  = 2'b00;
        forwardbE  = 2'b00;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        load_use_s = memreadE && regwriteE && (rdE != {AW{1'b0}}) &&
                     ((rdE == rs1D) || (rdE == rs2D));
        if (rst) begin
            forwardaE = fwd_sel(rs1E, rdM, regwriteM, rdW, regwriteW);
            forwardbE = fwd_sel(rs2E, rdM, regwriteM, rdW, regwriteW);
            if (mem_stall_s) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
            end else if (isbranchtakenE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (load_use_s) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else begin
                stallF = 1'b0;
            end
        end else begin
            forwardaE = 2'b00;
            forwardbE = 2'b00;
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stallF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flushE && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// Bench for hazard_ctrl_param: four instances (MEM_LAT 1, 3, 4, 8) share one stimulus stream.
module tb_hazard_ctrl_param;
    localparam int N = 4;

    function automatic int lat_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteE, memreadE, isbranchtakenE, regwriteM, memreqM, regwriteW;
    logic [1:0] fa [N];
    logic [1:0] fb [N];
    logic       sf [N];
    logic       sd [N];
    logic       se [N];
    logic       sm [N];
    logic       fd [N];
    logic       fe [N];
`ifdef HAZARD_STATS_EN
    logic [31:0] sc [N];
    logic [31:0] fc [N];
`endif
    int total_checks  = 0;
    int passed_checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hazard_ctrl_param #(.AW(5), .MEM_LAT(lat_of(g))) u_dut (
            .clk(clk), .rst(rst),
            .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
            .regwriteE(regwriteE), .memreadE(memreadE), .isbranchtakenE(isbranchtakenE),
            .rdM(rdM), .regwriteM(regwriteM), .memreqM(memreqM),
            .rdW(rdW), .regwriteW(regwriteW),
            .forwardaE(fa[g]), .forwardbE(fb[g]),
            .stallF(sf[g]), .stallD(sd[g]), .stallE(se[g]), .stallM(sm[g]),
            .flushD(fd[g]), .flushE(fe[g])
`ifdef HAZARD_STATS_EN
            , .stall_cnt(sc[g]), .flush_cnt(fc[g])
`endif
        );
    end

    function automatic logic [9:0] outs(input int g);
        return {fa[g], fb[g], sf[g], sd[g], se[g], sm[g], fd[g], fe[g]};
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (regwriteM && rdM != 5'd0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0; rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
        regwriteE = 1'b0; memreadE = 1'b0; isbranchtakenE = 1'b0;
        regwriteM = 1'b0; memreqM = 1'b0; regwriteW = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        regwriteM = 1'b1; rdM = 5'd3; rs1E = 5'd3; rs2E = 5'd3; regwriteW = 1'b1; rdW = 5'd3;
        memreqM = 1'b1; isbranchtakenE = 1'b1; memreadE = 1'b1; regwriteE = 1'b1; rdE = 5'd2; rs1D = 5'd2;
        #2;
        for (int g = 0; g < N; g++) begin
            total_checks++;
            if (outs(g) !== 10'b0) $display("FAIL reset_outs lat=%0d got=%b exp=%b", lat_of(g), outs(g), 10'b0);
            else passed_checks++;
        end
        step();
        total_checks++;
        if (outs(3) !== 10'b0) $display("FAIL reset_outs_after_edge got=%b exp=%b", outs(3), 10'b0);
        else passed_checks++;
        clear_inputs();
        rst = 1'b1;
    endtask

    task automatic test_forwarding();
        // regwriteM, rdM, regwriteW, rdW, rs1E, rs2E, expected fa, expected fb
        int t [6][8] = '{'{1, 3, 1, 3, 3, 0, 2, 0}, '{1, 0, 1, 3, 3, 0, 1, 0},
                         '{1, 7, 1, 3, 3, 7, 1, 2}, '{0, 3, 0, 3, 3, 3, 0, 0},
                         '{1, 0, 1, 0, 0, 0, 0, 0}, '{1, 5, 1, 5, 5, 5, 2, 2}};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            regwriteM = 1'(t[i][0]); rdM = 5'(t[i][1]); regwriteW = 1'(t[i][2]);
            rdW = 5'(t[i][3]); rs1E = 5'(t[i][4]); rs2E = 5'(t[i][5]);
            @(negedge clk);
            total_checks++;
            if ({fa[0], fb[0]} !== {2'(t[i][6]), 2'(t[i][7])})
                $display("FAIL forward case=%0d got=%b exp=%b", i, {fa[0], fb[0]}, {2'(t[i][6]), 2'(t[i][7])});
            else passed_checks++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        // memreadE, regwriteE, rdE, rs1D, rs2D, expect stall
        int t [6][6] = '{'{1, 1, 5, 1, 5, 1}, '{0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0},
                         '{1, 0, 6, 6, 0, 0}, '{1, 1, 6, 6, 2, 1}, '{0, 1, 6, 6, 6, 0}};
        logic [5:0] exp;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            memreadE = 1'(t[i][0]); regwriteE = 1'(t[i][1]); rdE = 5'(t[i][2]);
            rs1D = 5'(t[i][3]); rs2D = 5'(t[i][4]);
            @(negedge clk);
            exp = (t[i][5] != 0) ? 6'b110001 : 6'b000000;
            total_checks++;
            if ({sf[2], sd[2], se[2], sm[2], fd[2], fe[2]} !== exp)
                $display("FAIL load_use case=%0d got=%b exp=%b", i, {sf[2], sd[2], se[2], sm[2], fd[2], fe[2]}, exp);
            else passed_checks++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_memwait();
        logic exp;
        do_reset();
        memreqM = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = (c != 3);
            total_checks++;
            if ({sf[2], sd[2], se[2], sm[2]} !== {4{exp}})
                $display("FAIL memwait_lat4 cycle=%0d got=%b exp=%b", c, {sf[2], sd[2], se[2], sm[2]}, {4{exp}});
            else passed_checks++;
            total_checks++;
            if ({sf[0], sd[0], se[0], sm[0]} !== 4'b0000)
                $display("FAIL memwait_lat1 cycle=%0d got=%b exp=%b", c, {sf[0], sd[0], se[0], sm[0]}, 4'b0000);
            else passed_checks++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_branch_wait();
        logic [2:0] exp3;
        logic [5:0] exp6;
        do_reset();
        memreqM = 1'b1; isbranchtakenE = 1'b1;
        memreadE = 1'b1; regwriteE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp3 = (c < 2) ? 3'b100 : 3'b011;
            total_checks++;
            if ({sf[1], fd[1], fe[1]} !== exp3)
                $display("FAIL branch_wait_lat3 cycle=%0d got=%b exp=%b", c, {sf[1], fd[1], fe[1]}, exp3);
            else passed_checks++;
            total_checks++;
            if ({sf[0], sd[0], fd[0], fe[0]} !== 4'b0011)
                $display("FAIL branch_over_loaduse cycle=%0d got=%b exp=%b", c, {sf[0], sd[0], fd[0], fe[0]}, 4'b0011);
            else passed_checks++;
            step();
        end
        do_reset();
        memreqM = 1'b1; memreadE = 1'b1; regwriteE = 1'b1; rdE = 5'd4; rs2D = 5'd4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            exp6 = (c < 2) ? 6'b111100 : 6'b110001;
            total_checks++;
            if ({sf[1], sd[1], se[1], sm[1], fd[1], fe[1]} !== exp6)
                $display("FAIL wait_then_loaduse cycle=%0d got=%b exp=%b", c, {sf[1], sd[1], se[1], sm[1], fd[1], fe[1]}, exp6);
            else passed_checks++;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_reset_midwait();
        do_reset();
        memreqM = 1'b1;
        step();
        memreqM = 1'b0;
        #2;
        total_checks++;
        if (sf[3] !== 1'b1) $display("FAIL midwait_stalled got=%b exp=%b", sf[3], 1'b1);
        else passed_checks++;
        rst = 1'b0;
        #1;
        total_checks++;
        if (outs(3) !== 10'b0) $display("FAIL midwait_async_reset got=%b exp=%b", outs(3), 10'b0);
        else passed_checks++;
        step();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total_checks++;
            if ({sf[3], sd[3], se[3], sm[3]} !== 4'b0000)
                $display("FAIL midwait_after_reset cycle=%0d got=%b exp=%b", c, {sf[3], sd[3], se[3], sm[3]}, 4'b0000);
            else passed_checks++;
            step();
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        do_reset();
        memreadE = 1'b1; regwriteE = 1'b1; rdE = 5'd5; rs2D = 5'd5;
        step();
        clear_inputs();
        memreqM = 1'b1;
        for (int c = 0; c < 4; c++) step();
        memreqM = 1'b0;
        @(negedge clk);
        total_checks++;
        if ({sc[2], fc[2]} !== {32'd4, 32'd1})
            $display("FAIL stats_lat4 got=%0d/%0d exp=4/1", sc[2], fc[2]);
        else passed_checks++;
        total_checks++;
        if ({sc[0], fc[0]} !== {32'd1, 32'd1})
            $display("FAIL stats_lat1 got=%0d/%0d exp=1/1", sc[0], fc[0]);
        else passed_checks++;
        step();
    endtask
`endif

    // Reference: each access stalls MEM_LAT-1 cycles, then one release cycle ignores memreqM.
    task automatic test_random();
        int         left [N];
        bit         ign  [N];
        int         m_sc [N];
        int         m_fc [N];
        bit         mem, lu;
        logic [9:0] exp;
        do_reset();
        for (int g = 0; g < N; g++) begin
            left[g] = 0; ign[g] = 1'b0; m_sc[g] = 0; m_fc[g] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1)); memreadE = 1'($urandom_range(0, 1));
            regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
            isbranchtakenE = ($urandom_range(0, 5) == 0);
            memreqM        = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            lu = memreadE && regwriteE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
            for (int g = 0; g < N; g++) begin
                mem = 1'b0;
                if (left[g] > 0) begin
                    mem = 1'b1;
                    left[g] = left[g] - 1;
                end else if (!ign[g] && memreqM && lat_of(g) > 1) begin
                    mem = 1'b1;
                    left[g] = lat_of(g) - 2;
                end
                ign[g] = mem && (left[g] == 0);
                exp = {model_fwd(rs1E), model_fwd(rs2E), 6'b000000};
                if (mem) exp[5:0] = 6'b111100;
                else if (isbranchtakenE) exp[5:0] = 6'b000011;
                else if (lu) exp[5:0] = 6'b110001;
                m_sc[g] += exp[5] ? 1 : 0;
                m_fc[g] += exp[0] ? 1 : 0;
                total_checks++;
                if (outs(g) !== exp)
                    $display("FAIL random cyc=%0d lat=%0d got=%b exp=%b", cyc, lat_of(g), outs(g), exp);
                else passed_checks++;
            end
            step();
        end
`ifdef HAZARD_STATS_EN
        for (int g = 0; g < N; g++) begin
            total_checks++;
            if ({sc[g], fc[g]} !== {32'(m_sc[g]), 32'(m_fc[g])})
                $display("FAIL random_stats lat=%0d got=%0d/%0d exp=%0d/%0d", lat_of(g), sc[g], fc[g], m_sc[g], m_fc[g]);
            else passed_checks++;
        end
`endif
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_memwait();
        test_branch_wait();
        test_reset_midwait();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
